// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline enable/flush sequencing, dmem wait tracking, halt latch and stall counter
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             idex_dmemREN,
    input  logic [4:0]       idex_dest,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             mem_taken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             dmem_mask,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, DWAIT, DDONE, HALT} state_t;

    state_t           state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mask_w, dreq, adv, load_use;

    // The access already completed in DDONE; masking stops the datapath re-issuing it.
    assign mask_w   = nRST & ((state_q == DDONE) | (state_q == HALT));
    assign dreq     = (dmemREN | dmemWEN) & ~mask_w;
    assign load_use = idex_dmemREN & (idex_dest != 5'd0) &
                      ((idex_dest == ifid_rs) | (idex_dest == ifid_rt));

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        stall_cnt_d = stall_cnt_q;
        adv         = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        unique case (state_q)
            RUN: begin
                adv = ihit & ~dreq;
                if (dreq) state_d = dhit ? DDONE : DWAIT;
            end
            DWAIT: if (dhit) state_d = DDONE;
            DDONE: begin
                adv = ihit;
                if (ihit) state_d = RUN;
            end
            default: ;
        endcase

        if (adv) begin
            if (mem_halt) begin
                memwb_en = 1'b1;
                state_d  = HALT;
                halt_d   = 1'b1;
            end else if (mem_taken) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
            end else if (load_use) begin
                {idex_en, exmem_en, memwb_en} = 3'b111;
                idex_flush = 1'b1;
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            end
        end

        if ((state_q != HALT) && !adv && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        if (!nRST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b000;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem_mask = mask_w;
    assign halt      = halt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, dmemREN, dmemWEN, idex_dmemREN, mem_taken, mem_halt;
    logic [4:0] idex_dest, ifid_rs, ifid_rt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, dmem_mask, halt;
    logic [3:0] stall_cnt;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .idex_dmemREN(idex_dmemREN),
        .idex_dest(idex_dest), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .mem_taken(mem_taken), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .dmem_mask(dmem_mask), .halt(halt),
        .stall_cnt(stall_cnt)
    );

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, mask, halt}
    localparam logic [9:0] ZERO  = 10'b00000_000_00;
    localparam logic [9:0] ADV   = 10'b11111_000_00;
    localparam logic [9:0] ADVM  = 10'b11111_000_10;
    localparam logic [9:0] MASK  = 10'b00000_000_10;
    localparam logic [9:0] LUSE  = 10'b00111_010_00;
    localparam logic [9:0] TAKEN = 10'b11111_111_00;
    localparam logic [9:0] HSTEP = 10'b00001_000_00;
    localparam logic [9:0] HOLD  = 10'b00000_000_11;
    localparam logic [9:0] RHALT = 10'b00000_000_01;

    typedef struct {
        string      tag;
        logic [9:0] outs;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] cnt_model = 4'd0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rn, input logic ih, input logic dh,
                       input logic ren, input logic wen, input logic idr,
                       input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic tk, input logic mh, input logic [9:0] e);
        exp_t x;
        nRST = rn; ihit = ih; dhit = dh; dmemREN = ren; dmemWEN = wen;
        idex_dmemREN = idr; idex_dest = dst; ifid_rs = rs; ifid_rt = rt;
        mem_taken = tk; mem_halt = mh;
        x.tag = tag; x.outs = e; x.cnt = cnt_model;
        sb.push_back(x);
        @(negedge CLK);
        x = sb.pop_front();
        check_val({x.tag, ".outs"}, {22'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, dmem_mask, halt}, {22'd0, x.outs});
        check_val({x.tag, ".cnt"}, {28'd0, stall_cnt}, {28'd0, x.cnt});
        @(posedge CLK);
        #1;
        // Frozen cycle = not halted and MEM/WB did not latch.
        if (!rn) cnt_model = 4'd0;
        else if (!e[0] && !e[5] && cnt_model != 4'd15) cnt_model = cnt_model + 4'd1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        idex_dmemREN = 1'b0; idex_dest = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        mem_taken = 1'b0; mem_halt = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 2; i++) cyc("rst", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("rel_adv", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV);
        cyc("no_ihit", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);

        cyc("rst_ld", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("ld_run",   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("ld_wait1", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("ld_wait2", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("ld_wait3", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("ld_done",  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MASK);
        cyc("ld_adv",   1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ADVM);
        cyc("ld_back",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV);

        cyc("st_both", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("st_done", 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, ADVM);

        cyc("lu_rt",   1, 1, 0, 0, 0, 1, 8, 3, 8, 0, 0, LUSE);
        cyc("lu_rs",   1, 1, 0, 0, 0, 1, 5, 5, 9, 0, 0, LUSE);
        cyc("lu_zero", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, ADV);
        cyc("lu_miss", 1, 1, 0, 0, 0, 1, 7, 3, 4, 0, 0, ADV);
        cyc("lu_noload", 1, 1, 0, 0, 0, 0, 8, 8, 8, 0, 0, ADV);
        cyc("br_lu",   1, 1, 0, 0, 0, 1, 8, 3, 8, 1, 0, TAKEN);
        cyc("br_stall", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO);

        cyc("dw_enter", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("dw_rst",   0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("dw_after", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV);

        cyc("h_stall", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("h_step",  1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, HSTEP);
        for (int i = 0; i < 12; i++) cyc("h_hold", 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, HOLD);
        cyc("h_rst",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RHALT);
        cyc("h_clear", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV);

        for (int i = 0; i < 20; i++) cyc("sat", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
        cyc("sat_end", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV);
        check_val("sat_model", {28'd0, stall_cnt}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It tracks the outstanding data-memory access in the MEM stage, inserts load-use bubbles and flushes on a taken branch or jump. It also latches halt and counts frozen cycles for the perf counters.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  synchronous reset, active-low.
ihit  in  1  instruction fetch complete this cycle.
dhit  in  1  data access complete this cycle.
dmemREN  in  1  MEM-stage load request, from EX/MEM WB/MEM ctrl.
dmemWEN  in  1  MEM-stage store request.
idex_dmemREN  in  1  EX-stage instruction is a load.
idex_dest  in  5  EX-stage destination register.
ifid_rs  in  5  ID-stage source register rs.
ifid_rt  in  5  ID-stage source register rt.
mem_taken  in  1  branch taken or jump resolved in MEM.
mem_halt  in  1  MEM-stage instruction is HALT.
pc_en  out  1  PC update enable.
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (zero control) on enable.
dmem_mask  out  1  datapath gates dmemREN/dmemWEN to 0 when high.
halt  out  1  sticky halt.
stall_cnt  out  CNT_W  saturating count of frozen cycles.

Behaviour:
- Reset: synchronous active-low. A rising CLK edge with nRST=0 sets state=RUN, halt=0, stall_cnt=0. While nRST=0, all enables, flushes and dmem_mask are forced to 0.
- Define dreq = (dmemREN|dmemWEN) & ~dmem_mask.
- Define adv = the whole pipeline advances this cycle. In RUN: adv = ihit & ~dreq. In DDONE: adv = ihit. In all other states: adv = 0.
- On adv=1: pc_en and all four latch enables are 1, except as modified by the priority rules below.
- On adv=0: all enables are 0 and no flush is asserted.
- State RUN:
  - dreq & dhit: transition to DDONE.
  - dreq & ~dhit: transition to DWAIT.
  - else: remain in RUN.
- State DWAIT: dmem_mask=0, everything frozen. On dhit, transition to DDONE.
- State DDONE:
  - dmem_mask=1; the access is not re-issued.
  - On ihit: adv=1, transition to RUN.
- State HALT: all enables 0, dmem_mask=1, halt=1. The only exit is reset.
- Priority when adv=1 (highest first):
  1. mem_halt: memwb_en=1, all other enables 0; next state HALT, halt<=1.
  2. mem_taken: pc_en=1 loads the target; ifid_flush=idex_flush=exmem_flush=1. The load-use rule is ignored.
  3. Load-use: condition is idex_dmemREN & idex_dest!=0 & (idex_dest==ifid_rs | idex_dest==ifid_rt). Action: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1; exmem_en and memwb_en stay 1.
  4. Otherwise: plain advance with no flushes.
- Flush signals are meaningful only when the matching enable is 1; they are driven 0 otherwise.
- stall_cnt:
  - Increments on every post-reset cycle where state!=HALT and adv=0.
  - Holds at 2^CNT_W-1 (no wrap).
  - Frozen in HALT.
- ihit and dhit are asserted simultaneously in RUN with dreq=1: dhit wins (transition to DDONE) and the pipe does not advance that cycle.
- Reset asserted mid-DWAIT or mid-DDONE: returns to RUN next edge; no enable pulses on the reset cycle.
- Outputs are combinational from registered state and inputs. Latency from dhit to pipeline advance is at least 1 cycle (the DDONE visit).

Test Plan:
- Reset: hold nRST=0 for 2 cycles, ihit=1 -> all enables 0, halt=0, stall_cnt=0. Release -> pc_en and all latch enables 1 on the first ihit cycle.
- Load with 3-cycle data latency: dmemREN=1, dhit low for 3 cycles then high, ihit high 1 cycle after that -> path RUN->DWAIT x3->DDONE->RUN; enables 0 for 5 cycles; dmem_mask=1 only in DDONE; stall_cnt=5.
- Load-use: idex_dmemREN=1, idex_dest=8, ifid_rt=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Repeat with idex_dest=0 -> plain advance.
- Branch beats load-use: mem_taken=1 together with the load-use condition, ihit=1 -> pc_en=1; ifid, idex and exmem flushes all 1.
- Halt: mem_halt=1, ihit=1 -> one cycle memwb_en=1 only, then halt=1 with all enables 0 for 10+ cycles despite ihit; stall_cnt unchanged; nRST=0 clears it.
- Saturation with CNT_W=4: freeze for 20 cycles -> stall_cnt stays at 15.
